sdhci_dat_rx: RTL and testbench
===============================

// Module: sdhci_dat_rx
// PURPOSE
//  SD DAT-line block receiver feeding the read-side buffer (sram_shift_reg push port).
//  Samples DAT[3:0] on SD-clock strobes, finds the start bit and deserialises one block.
//  Packs bytes into 32-bit words, checks the per-lane CRC16 and the end bit,
//  and flags data timeout. Sits between the SD pads/clock divider and the read buffer.
// PARAMETERS
//  TimeoutWidth  24  width of data-timeout counter, counted in SD-clock strobes
// PORTS
//  clk_i            in   1   system clock; single clock domain
//  rst_ni           in   1   synchronous active-low reset
//  sd_clk_en_i      in   1   1-cycle strobe at each SD-clock rising edge (sample point)
//  start_i          in   1   pulse: arm receiver for one block (ignored unless IDLE)
//  abort_i          in   1   pulse: abandon current block
//  bus_width_4_i    in   1   1: 4-bit bus, 0: 1-bit bus (DAT0 only)
//  block_size_i     in   12  block length in bytes, 1..2048 (0 treated as 2048)
//  timeout_i        in   TimeoutWidth  strobes allowed before the start bit
//  dat_i            in   4   DAT[3:0], already synchronised
//  buf_full_i       in   1   read buffer full
//  push_o           out  1   1-cycle push into read buffer
//  push_data_o      out  32  word to push; first received byte in [7:0]
//  sd_clk_stop_o    out  1   request clock divider to stop SD clock (word pending, buffer full)
//  busy_o           out  1   state != IDLE
//  done_o           out  1   1-cycle pulse at end of block (also on error completion)
//  crc_error_o      out  1   1-cycle pulse with done_o if any lane CRC16 mismatches
//  end_bit_error_o  out  1   1-cycle pulse with done_o if any active lane end bit is 0
//  timeout_error_o  out  1   1-cycle pulse, no start bit within timeout_i strobes
//  overrun_error_o  out  1   1-cycle pulse, strobe arrived while a word was pending
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; counters, CRC registers and word register cleared.
//  FSM: IDLE -start_i-> WAIT_START -start bit-> DATA -last byte-> CRC -16 beats-> END -> IDLE.
//  All state advances happen only on cycles with sd_clk_en_i=1, except push/done logic.
//  WAIT_START: start bit = DAT0==0 (1-bit) / all four lanes 0 (4-bit).
//   The strobe carrying the start bit is not data.
//   Strobe counter increments per strobe; reaching timeout_i -> timeout_error_o, IDLE.
//   timeout_i==0 disables the timeout.
//  DATA: bytes MSB first. 1-bit: 8 strobes/byte.
//   4-bit: 2 strobes/byte, DAT3..DAT0 = bits 7..4 then 3..0.
//   Byte k of the word goes to bits [8k+7:8k].
//   After 4th byte or last byte of the block, word is pending; unused upper bytes are 0.
//  Push: pending word -> push_o=1 on the next clk cycle if !buf_full_i, else
//   sd_clk_stop_o=1 (combinational) until buf_full_i drops, then push.
//   push_data_o is stable while push_o=1.
//  Strobe while a word is still pending: overrun_error_o pulse; the strobe's bits are dropped.
//  CRC: CRC16-CCITT (x^16+x^12+x^5+1), per lane, seeded 0 at start bit.
//   Covers all data bits of the lane. 16 CRC bits per lane follow, MSB first.
//   Received CRC bits are compared with the computed CRC; inactive lanes are ignored.
//  END: one strobe; every active lane must be 1. done_o fires the cycle after END is sampled.
//   Fires only once the final word has been pushed; error pulses go out with done_o.
//  abort_i (any state): IDLE next cycle. Pending word discarded, no push, no done_o.
//  abort_i beats simultaneous start_i.
//  bus_width_4_i and block_size_i are captured on start_i; later changes are ignored mid-block.
// CONFIGURATION
//  SDHCI_DAT_4BIT_EN defined: 4-bit mode supported, four CRC16 instances.
//  Not defined: bus_width_4_i ignored (always 1-bit), DAT[3:1] unused,
//   single CRC16 instance, 4-bit start/end checks removed.
// STRUCTURE
//  sdhci_pkg: state enum dat_rx_state_e, CRC16 polynomial constant, CrcLen=16,
//   MaxBlockBytes=2048.
//  Sub-module sdhci_crc16 (1-bit serial CRC16: clear, enable, bit in, 16-bit crc out),
//   one instance per lane.
// TESTING
//  1-bit, size 4, bytes DE AD BE EF, good CRC -> one push 0xEFBEADDE; done_o, no errors.
//  4-bit, size 512, random data, good CRC -> 128 pushes in order; done_o, no errors.
//  4-bit, DAT2 CRC bit 5 flipped -> all 128 pushes, done_o with crc_error_o=1.
//  timeout_i=10, DAT held 1 -> timeout_error_o on 10th strobe, busy_o=0 next cycle, no push.
//  buf_full_i=1 when word 1 completes -> sd_clk_stop_o=1, no push.
//   Release after 20 cycles -> push next cycle, data intact.
//  abort_i mid-DATA after 6 bytes -> IDLE next cycle; one push only (first word), no done_o.

Source files
------------

// File: rtl/sdhci_pkg.sv
// Shared types and constants for the SD host DAT-line receive path.
// Holds the receiver state enum and the serial CRC16-CCITT step used by every lane.
package sdhci_pkg;

  localparam int CrcLen        = 16;
  localparam int MaxBlockBytes = 2048;

  // x^16 + x^12 + x^5 + 1
  localparam logic [CrcLen-1:0] Crc16Poly = 16'h1021;

  typedef enum logic [2:0] {
    DAT_IDLE,
    DAT_WAIT_START,
    DAT_DATA,
    DAT_CRC,
    DAT_END,
    DAT_DONE
  } dat_rx_state_e;

  function automatic logic [CrcLen-1:0] crc16_step(input logic [CrcLen-1:0] crc,
                                                   input logic              bit_in);
    logic fb;
    fb = bit_in ^ crc[CrcLen-1];
    return {crc[CrcLen-2:0], 1'b0} ^ (fb ? Crc16Poly : '0);
  endfunction

endpackage

// File: rtl/sdhci_crc16.sv
// One-bit serial CRC16-CCITT accumulator for a single DAT lane.
// clear_i reseeds to zero and wins over en_i.
module sdhci_crc16
  import sdhci_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic              bit_i,
  output logic [CrcLen-1:0] crc_o
);

  logic [CrcLen-1:0] r_crc;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      r_crc <= '0;
    end else if (en_i) begin
      r_crc <= crc16_step(r_crc, bit_i);
    end
  end

  assign crc_o = r_crc;

endmodule

// File: rtl/sdhci_dat_rx.sv
// SD DAT-line block receiver: start-bit hunt, deserialise into 32-bit words, CRC16/end-bit check.
// Define SDHCI_DAT_4BIT_EN for 4-bit bus support (four CRC lanes); otherwise DAT0-only 1-bit mode.
module sdhci_dat_rx
  import sdhci_pkg::*;
#(
  parameter int TimeoutWidth = 24
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    sd_clk_en_i,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic                    bus_width_4_i,
  input  logic [11:0]             block_size_i,
  input  logic [TimeoutWidth-1:0] timeout_i,
  input  logic [3:0]              dat_i,
  input  logic                    buf_full_i,
  output logic                    push_o,
  output logic [31:0]             push_data_o,
  output logic                    sd_clk_stop_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    crc_error_o,
  output logic                    end_bit_error_o,
  output logic                    timeout_error_o,
  output logic                    overrun_error_o
);

`ifdef SDHCI_DAT_4BIT_EN
  localparam int NumLanes = 4;
`else
  localparam int NumLanes = 1;
`endif
  localparam int CntW = $clog2(MaxBlockBytes);

  dat_rx_state_e           r_state, w_next;
  logic                    r_bw4, w_bw4_in;
  logic [CntW-1:0]         r_last_idx, r_byte_cnt;
  logic [TimeoutWidth-1:0] r_to_cnt, w_to_next;
  logic [2:0]              r_beat;
  logic [7:0]              r_byte, w_byte_new;
  logic [31:0]             r_word, r_push_data, w_word_asm;
  logic                    r_pending;
  logic [3:0]              r_crc_cnt, w_crc_idx;
  logic                    r_crc_err, r_end_err;
  logic                    w_strobe, w_start_bit, w_end_bad, w_byte_done, w_last_byte, w_word_done;
  logic                    w_crc_clr, w_crc_en, w_crc_mis, w_push, w_done, w_timeout;
  logic [CrcLen-1:0]       w_crc [NumLanes];

`ifdef SDHCI_DAT_4BIT_EN
  assign w_bw4_in = bus_width_4_i;
`else
  logic w_unused;
  assign w_bw4_in = 1'b0;
  assign w_unused = bus_width_4_i;
`endif

  // A strobe arriving while a word still waits for the buffer carries no usable bits.
  assign w_strobe    = sd_clk_en_i & ~r_pending;
  assign w_start_bit = r_bw4 ? (dat_i == 4'h0) : ~dat_i[0];
  assign w_end_bad   = r_bw4 ? (dat_i != 4'hF) : ~dat_i[0];
  assign w_byte_done = r_bw4 ? r_beat[0] : (r_beat == 3'd7);
  assign w_byte_new  = r_bw4 ? {r_byte[3:0], dat_i} : {r_byte[6:0], dat_i[0]};
  assign w_last_byte = (r_byte_cnt == r_last_idx);
  assign w_word_done = (r_byte_cnt[1:0] == 2'd3) | w_last_byte;
  assign w_to_next   = r_to_cnt + TimeoutWidth'(1);
  assign w_crc_idx   = ~r_crc_cnt;
  assign w_crc_clr   = (r_state == DAT_WAIT_START) & w_strobe & w_start_bit;
  assign w_crc_en    = (r_state == DAT_DATA) & w_strobe;
  assign w_push      = r_pending & ~buf_full_i & ~abort_i;

  always_comb begin
    w_word_asm = r_word;
    w_word_asm[8*r_byte_cnt[1:0] +: 8] = w_byte_new;
  end

  for (genvar l = 0; l < NumLanes; l++) begin : g_lane
    sdhci_crc16 u_crc (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (w_crc_clr),
      .en_i    (w_crc_en),
      .bit_i   (dat_i[l]),
      .crc_o   (w_crc[l])
    );
  end

  always_comb begin
    w_crc_mis = 1'b0;
    for (int l = 0; l < NumLanes; l++) begin
      if ((l == 0 || r_bw4) && (dat_i[l] != w_crc[l][w_crc_idx])) w_crc_mis = 1'b1;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      DAT_IDLE:       if (start_i) w_next = DAT_WAIT_START;
      DAT_WAIT_START: if (w_strobe) begin
        if (w_start_bit) begin
          w_next = DAT_DATA;
        end else if (timeout_i != '0 && w_to_next == timeout_i) begin
          w_timeout = 1'b1;
          w_next    = DAT_IDLE;
        end
      end
      DAT_DATA:       if (w_strobe && w_byte_done && w_last_byte) w_next = DAT_CRC;
      DAT_CRC:        if (w_strobe && r_crc_cnt == 4'd15) w_next = DAT_END;
      DAT_END:        if (w_strobe) w_next = DAT_DONE;
      DAT_DONE:       if (!r_pending) begin
        w_done = 1'b1;
        w_next = DAT_IDLE;
      end
      default:        w_next = DAT_IDLE;
    endcase
    if (abort_i) begin
      w_next    = DAT_IDLE;
      w_timeout = 1'b0;
      w_done    = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= DAT_IDLE;
      r_bw4 <= 1'b0;
      r_last_idx <= '0;
      r_byte_cnt <= '0;
      r_to_cnt <= '0;
      r_beat <= '0;
      r_byte <= '0;
      r_word <= '0;
      r_push_data <= '0;
      r_pending <= 1'b0;
      r_crc_cnt <= '0;
      r_crc_err <= 1'b0;
      r_end_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_push) r_pending <= 1'b0;
      case (r_state)
        DAT_IDLE: if (start_i) begin
          r_bw4      <= w_bw4_in;
          r_last_idx <= (block_size_i == '0) ? CntW'(MaxBlockBytes - 1) : CntW'(block_size_i - 12'd1);
          r_to_cnt   <= '0;
          r_crc_err  <= 1'b0;
          r_end_err  <= 1'b0;
        end
        DAT_WAIT_START: if (w_strobe) begin
          r_to_cnt   <= w_to_next;
          r_beat     <= '0;
          r_byte_cnt <= '0;
          r_word     <= '0;
          r_crc_cnt  <= '0;
        end
        DAT_DATA: if (w_strobe) begin
          r_byte <= w_byte_new;
          r_beat <= r_beat + 3'd1;
          if (w_byte_done) begin
            r_beat     <= '0;
            r_byte_cnt <= r_byte_cnt + CntW'(1);
            if (w_word_done) begin
              r_push_data <= w_word_asm;
              r_pending   <= 1'b1;
              r_word      <= '0;
            end else begin
              r_word <= w_word_asm;
            end
          end
        end
        DAT_CRC: if (w_strobe) begin
          r_crc_cnt <= r_crc_cnt + 4'd1;
          if (w_crc_mis) r_crc_err <= 1'b1;
        end
        DAT_END: if (w_strobe && w_end_bad) r_end_err <= 1'b1;
        default: ;
      endcase
      if (abort_i) r_pending <= 1'b0;
    end
  end

  assign push_o          = w_push;
  assign push_data_o     = r_push_data;
  assign sd_clk_stop_o   = r_pending & buf_full_i;
  assign busy_o          = (r_state != DAT_IDLE);
  assign done_o          = w_done;
  assign crc_error_o     = w_done & r_crc_err;
  assign end_bit_error_o = w_done & r_end_err;
  assign timeout_error_o = w_timeout;
  assign overrun_error_o = sd_clk_en_i & r_pending &
                           (r_state == DAT_DATA || r_state == DAT_CRC || r_state == DAT_END);

endmodule

// File: tb/tb_sdhci_dat_rx.sv
`timescale 1ns/1ps
// Directed bench for sdhci_dat_rx: expected push words queued at stimulus time, popped on push_o.
// 4-bit scenarios are compiled in only when SDHCI_DAT_4BIT_EN is defined.
module tb_sdhci_dat_rx;

  localparam int Pre = 2;  // idle strobes before the start bit

  logic        clk_i = 1'b0;
  logic        rst_ni, sd_clk_en_i, start_i, abort_i, bus_width_4_i, buf_full_i;
  logic [11:0] block_size_i;
  logic [23:0] timeout_i;
  logic [3:0]  dat_i;
  logic        push_o, sd_clk_stop_o, busy_o, done_o;
  logic        crc_error_o, end_bit_error_o, timeout_error_o, overrun_error_o;
  logic [31:0] push_data_o;

  always #5 clk_i = ~clk_i;

  sdhci_dat_rx #(.TimeoutWidth(24)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .sd_clk_en_i     (sd_clk_en_i),
    .start_i         (start_i),
    .abort_i         (abort_i),
    .bus_width_4_i   (bus_width_4_i),
    .block_size_i    (block_size_i),
    .timeout_i       (timeout_i),
    .dat_i           (dat_i),
    .buf_full_i      (buf_full_i),
    .push_o          (push_o),
    .push_data_o     (push_data_o),
    .sd_clk_stop_o   (sd_clk_stop_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .crc_error_o     (crc_error_o),
    .end_bit_error_o (end_bit_error_o),
    .timeout_error_o (timeout_error_o),
    .overrun_error_o (overrun_error_o)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  blk[$];
  logic [3:0]  beats[$];
  int          n_push = 0, n_done = 0, n_timeout = 0, n_overrun = 0;
  int          p_push, p_done;
  logic        last_crc = 1'b0, last_end = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic [15:0] n;
    n = {c[14:0], 1'b0};
    if (b ^ c[15]) n = n ^ 16'h1021;
    return n;
  endfunction

  // Output monitor: sampled mid low phase, after stimulus has settled.
  always begin
    @(negedge clk_i);
    #2;
    if (push_o) begin
      n_push++;
      if (exp_q.size() == 0) check("push_unexpected", 32'(exp_q.size()), 32'd1);
      else check("push_data", push_data_o, exp_q.pop_front());
    end
    if (done_o) begin
      n_done++;
      last_crc = crc_error_o;
      last_end = end_bit_error_o;
    end
    if (timeout_error_o) n_timeout++;
    if (overrun_error_o) n_overrun++;
  end

  // Builds the full strobe sequence for blk[] and queues the expected words.
  task automatic build_block(input logic bw4, input int flip_lane, input int flip_bit,
                             input logic [3:0] end_val);
    logic [15:0] crc [4];
    logic [3:0]  d;
    logic [31:0] w;
    beats.delete();
    for (int l = 0; l < 4; l++) crc[l] = 16'h0;
    for (int i = 0; i < Pre; i++) beats.push_back(4'hF);
    beats.push_back(bw4 ? 4'h0 : 4'hE);
    foreach (blk[i]) begin
      if (bw4) begin
        for (int h = 1; h >= 0; h--) begin
          d = blk[i][4*h +: 4];
          beats.push_back(d);
          for (int l = 0; l < 4; l++) crc[l] = crc_step(crc[l], d[l]);
        end
      end else begin
        for (int b = 7; b >= 0; b--) begin
          beats.push_back({3'b111, blk[i][b]});
          crc[0] = crc_step(crc[0], blk[i][b]);
        end
      end
    end
    for (int k = 15; k >= 0; k--) begin
      d = 4'hF;
      for (int l = 0; l < 4; l++) if (bw4 || l == 0) d[l] = crc[l][k];
      if (k == flip_bit && flip_lane >= 0) d[flip_lane] = ~d[flip_lane];
      beats.push_back(d);
    end
    beats.push_back(end_val);
    for (int i = 0; i < blk.size(); i += 4) begin
      w = '0;
      for (int j = 0; j < 4; j++) if (i + j < blk.size()) w[8*j +: 8] = blk[i+j];
      exp_q.push_back(w);
    end
  endtask

  task automatic random_blk(input int n);
    blk.delete();
    for (int i = 0; i < n; i++) blk.push_back(8'($urandom));
  endtask

  task automatic start_block(input logic bw4, input logic [11:0] size);
    @(negedge clk_i);
    bus_width_4_i = bw4;
    block_size_i  = size;
    start_i       = 1'b1;
    p_push        = n_push;
    p_done        = n_done;
    @(negedge clk_i);
    start_i       = 1'b0;
    bus_width_4_i = ~bw4;      // must be ignored mid-block
    block_size_i  = 12'd7;
    #2;
    check("busy_after_start", 32'(busy_o), 32'd1);
  endtask

  task automatic drive_beats(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk_i);
      dat_i       = beats[i];
      sd_clk_en_i = 1'b1;
      @(negedge clk_i);
      sd_clk_en_i = 1'b0;
    end
  endtask

  task automatic finish_block(input string tag, input logic exp_crc, input logic exp_end,
                              input int exp_words);
    for (int i = 0; i < 10 && n_done == p_done; i++) @(negedge clk_i);
    #3;
    check({tag, "_done"},     32'(n_done - p_done), 32'd1);
    check({tag, "_crc_err"},  32'(last_crc), 32'(exp_crc));
    check({tag, "_end_err"},  32'(last_end), 32'(exp_end));
    check({tag, "_pushes"},   32'(n_push - p_push), 32'(exp_words));
    check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_idle"},     32'(busy_o), 32'd0);
    dat_i = 4'hF;
  endtask

  initial begin
    rst_ni = 1'b0; sd_clk_en_i = 1'b0; start_i = 1'b0; abort_i = 1'b0;
    bus_width_4_i = 1'b0; block_size_i = 12'd4; timeout_i = 24'd100;
    dat_i = 4'hF; buf_full_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #2;
    check("rst_push",      32'(push_o), 32'd0);
    check("rst_busy",      32'(busy_o), 32'd0);
    check("rst_done",      32'(done_o), 32'd0);
    check("rst_clk_stop",  32'(sd_clk_stop_o), 32'd0);
    check("rst_push_data", push_data_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // 1-bit, DE AD BE EF -> single word EFBEADDE
    blk = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    build_block(1'b0, -1, 0, 4'hF);
    start_block(1'b0, 12'd4);
    drive_beats(0, beats.size() - 1);
    finish_block("deadbeef", 1'b0, 1'b0, 1);

    // 1-bit, 5 bytes: second word carries one byte, upper bytes zero
    random_blk(5);
    build_block(1'b0, -1, 0, 4'hF);
    start_block(1'b0, 12'd5);
    drive_beats(0, beats.size() - 1);
    finish_block("partial", 1'b0, 1'b0, 2);

    // 1-bit, CRC bit 5 flipped on DAT0
    random_blk(16);
    build_block(1'b0, 0, 5, 4'hF);
    start_block(1'b0, 12'd16);
    drive_beats(0, beats.size() - 1);
    finish_block("crc1", 1'b1, 1'b0, 4);

    // 1-bit, end bit low
    random_blk(4);
    build_block(1'b0, -1, 0, 4'hE);
    start_block(1'b0, 12'd4);
    drive_beats(0, beats.size() - 1);
    finish_block("endbit1", 1'b0, 1'b1, 1);

`ifdef SDHCI_DAT_4BIT_EN
    timeout_i = 24'd0;
    random_blk(512);
    build_block(1'b1, -1, 0, 4'hF);
    start_block(1'b1, 12'd512);
    drive_beats(0, beats.size() - 1);
    finish_block("wide512", 1'b0, 1'b0, 128);

    random_blk(512);
    build_block(1'b1, 2, 5, 4'hF);
    start_block(1'b1, 12'd512);
    drive_beats(0, beats.size() - 1);
    finish_block("wide_crc", 1'b1, 1'b0, 128);

    random_blk(2048);
    build_block(1'b1, -1, 0, 4'hF);
    start_block(1'b1, 12'd0);
    drive_beats(0, beats.size() - 1);
    finish_block("wide2048", 1'b0, 1'b0, 512);

    random_blk(8);
    build_block(1'b1, -1, 0, 4'hB);
    start_block(1'b1, 12'd8);
    drive_beats(0, beats.size() - 1);
    finish_block("wide_end", 1'b0, 1'b1, 2);
`endif

    // Timeout: 10 strobes with DAT high
    timeout_i = 24'd10;
    start_block(1'b0, 12'd4);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk_i);
      dat_i = 4'hF;
      sd_clk_en_i = 1'b1;
      #2;
      check("timeout_pulse", 32'(timeout_error_o), (k == 10) ? 32'd1 : 32'd0);
      @(negedge clk_i);
      sd_clk_en_i = 1'b0;
    end
    #2;
    check("timeout_idle", 32'(busy_o), 32'd0);
    check("timeout_no_push", 32'(n_push - p_push), 32'd0);
    check("timeout_count", 32'(n_timeout), 32'd1);
    timeout_i = 24'd100;

    // Buffer full when word 1 completes
    random_blk(8);
    build_block(1'b0, -1, 0, 4'hF);
    buf_full_i = 1'b1;
    start_block(1'b0, 12'd8);
    drive_beats(0, Pre + 32);
    #2;
    check("full_clk_stop", 32'(sd_clk_stop_o), 32'd1);
    repeat (20) @(negedge clk_i);
    #2;
    check("full_clk_stop_held", 32'(sd_clk_stop_o), 32'd1);
    check("full_no_push", 32'(n_push - p_push), 32'd0);
    @(negedge clk_i);
    buf_full_i = 1'b0;
    #3;
    check("release_push", 32'(n_push - p_push), 32'd1);
    @(negedge clk_i);
    #2;
    check("release_clk_run", 32'(sd_clk_stop_o), 32'd0);
    drive_beats(Pre + 33, beats.size() - 1);
    finish_block("full", 1'b0, 1'b0, 2);

    // Abort after 6 bytes: only the first word reaches the buffer
    random_blk(8);
    build_block(1'b0, -1, 0, 4'hF);
    void'(exp_q.pop_back());
    start_block(1'b0, 12'd8);
    drive_beats(0, Pre + 48);
    @(negedge clk_i);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    #2;
    check("abort_idle", 32'(busy_o), 32'd0);
    repeat (10) @(negedge clk_i);
    #2;
    check("abort_pushes", 32'(n_push - p_push), 32'd1);
    check("abort_no_done", 32'(n_done - p_done), 32'd0);
    check("abort_sb_empty", 32'(exp_q.size()), 32'd0);
    dat_i = 4'hF;

    // abort_i beats a simultaneous start_i
    @(negedge clk_i);
    start_i = 1'b1;
    abort_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    abort_i = 1'b0;
    #2;
    check("abort_beats_start", 32'(busy_o), 32'd0);

    check("no_overrun", 32'(n_overrun), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
